// File: rtl/mult_share_scheduler.sv
// Round-robin time-sharing of one external signed array multiplier among NUM_REQ requesters.
// Optional op_count/cnt_clr response counter is built when MULT_SCHED_CNT_EN is defined.
module mult_share_scheduler #(
  parameter  int NO_BITS = 5,
  parameter  int NUM_REQ = 4,
  parameter  int SETTLE  = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef MULT_SCHED_CNT_EN
  input  logic                         cnt_clr,
  output logic [15:0]                  op_count,
`endif
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*NO_BITS-1:0]   req_x,
  input  logic [NUM_REQ*NO_BITS-1:0]   req_y,
  output logic [NO_BITS-1:0]           mult_x,
  output logic [NO_BITS-1:0]           mult_y,
  input  logic [2*NO_BITS-1:0]         mult_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [2*NO_BITS-1:0]         rsp_prod,
  output logic                         busy,
  output logic [1:0]                   state_dbg
);

  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is only ever raised in IDLE, for the round-robin winner.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              accept;
  logic [CNT_W-1:0]  cnt;
  int                idx;

  // Circular search starting just above the last accepted requester.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

  assign accept = (state == IDLE) && any_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst_n so no grant can be seen while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && any_req) req_ready[winner] = 1'b1;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
    state_dbg = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_x     <= '0;
      mult_y     <= '0;
      rsp_id     <= '0;
      rsp_prod   <= '0;
      cnt        <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      mult_x     <= req_x[winner*NO_BITS +: NO_BITS];
      mult_y     <= req_y[winner*NO_BITS +: NO_BITS];
      rsp_id     <= winner;
      last_grant <= winner;
      cnt        <= CNT_W'(SETTLE);
    end else if (state == CALC) begin
      // Operands stay put while the array settles; capture once the count is spent.
      if (cnt != '0) cnt <= cnt - 1'b1;
      else           rsp_prod <= mult_out;
    end
  end

`ifdef MULT_SCHED_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      op_count <= '0;
    else if (cnt_clr)                op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: doc/mult_share_scheduler.md
# mult_share_scheduler

Time-shares one combinational signed array multiplier (NO_BITS × NO_BITS → 2·NO_BITS, two's complement in and out) among NUM_REQ requesters. Arbitration is round-robin. Operands are registered in front of the multiplier and held for a programmable number of settle cycles, because the ripple array path is too deep for one cycle at target frequency. The product is then captured and returned on a single valid/ready response port, tagged with the requester index.

## Interface
- NO_BITS, 5, operand width; multiplier product width is 2·NO_BITS
- NUM_REQ, 4, number of requesters (≥2)
- SETTLE, 2, extra cycles operands are held before capture (≥0)
- ID_W, $clog2(NUM_REQ), response tag width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero
- req_x  in  NUM_REQ·NO_BITS  operand x; requester k at slice [k·NO_BITS +: NO_BITS]
- req_y  in  NUM_REQ·NO_BITS  operand y; same packing
- mult_x, mult_y  out  NO_BITS each  registered operands to the multiplier
- mult_out  in  2·NO_BITS  multiplier product
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_prod  out  2·NO_BITS  signed product
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → CALC → RESP → IDLE.
- IDLE:
  - Winner is the first requester with req_valid set, searching upward circularly from last_grant+1.
  - req_ready[winner]=1, combinationally from req_valid and the pointer. All other req_ready bits are 0.
  - On the handshake edge: latch that requester's x into mult_x and its y into mult_y, latch the index into rsp_id, set last_grant to the winner, load cnt=SETTLE, and go to CALC.
- CALC:
  - req_ready is all zero.
  - mult_x and mult_y are stable.
  - If cnt≠0, decrement cnt.
  - If cnt==0, register mult_out into rsp_prod and go to RESP.
- RESP:
  - rsp_valid=1. rsp_id and rsp_prod are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE. No new grant occurs in that same cycle.
- Arithmetic: the block is a pure pass-through.
  - No sign handling and no truncation; rsp_prod equals mult_out exactly.
  - The multiplier handles the most-negative operand correctly: (−16)·(−16)=256 for NO_BITS=5.
- A requester that drops req_valid before being granted is simply skipped. Requests are not queued inside the block.
- last_grant advances only on an accepted request.
- Reset values:
  - state=IDLE; last_grant=NUM_REQ−1, so requester 0 has first priority.
  - mult_x=mult_y=0, rsp_prod=0, rsp_id=0, cnt=0.
  - rsp_valid=0, busy=0, req_ready=0 while rst_n is low.
- Reset asserted mid-operation aborts the in-flight operation. The result is lost and no rsp_valid pulse is produced.

## Timing
- Accept edge at cycle T. CALC spans SETTLE+1 cycles. rsp_valid rises at T+SETTLE+1.
- Minimum request-to-request spacing for a single requester is SETTLE+3 cycles.
- Each response stall cycle adds one cycle.
- rsp_valid, rsp_id, rsp_prod and mult_x/mult_y are registered outputs. req_ready is combinational in IDLE only.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ−1,0,…. No requester waits more than NUM_REQ−1 operations.

## Configuration
- MULT_SCHED_CNT_EN defined:
  - Adds output op_count, 16 bits, reset 0.
  - op_count increments on every response handshake and wraps from 16'hFFFF to 0.
  - Adds input cnt_clr, synchronous; it clears op_count. If a response handshake happens in the same cycle, clear wins.
- MULT_SCHED_CNT_EN not defined: neither port exists and there is no counter logic. All other behaviour is identical.

## Test plan
(NO_BITS=5, NUM_REQ=4, SETTLE=2)
- Reset then single request: req 0 sends x=3, y=−4, rsp_ready=1 → rsp_valid at T+3 with rsp_id=0 and rsp_prod=10'h3F4; busy low again one cycle later.
- Corner operands: x=−16, y=−16 → 10'h100. x=7, y=7 → 10'h031. x=−16, y=15 → 10'h310.
- All four requesters valid continuously after reset → grant order 0,1,2,3,0. Each rsp_id matches the grant, and each product matches that requester's operands.
- rsp_ready held low for 5 cycles in RESP → rsp_valid, rsp_id and rsp_prod stay stable. No req_ready is asserted. Normal grant resumes after the handshake.
- rst_n pulsed low during CALC → outputs return to reset values immediately. No response is produced. The next grant goes to requester 0.
- With MULT_SCHED_CNT_EN: 3 operations → op_count=3. cnt_clr asserted coincident with the 4th response handshake → op_count=0.
